tile_pattern_gen: RTL and testbench

Pseudo-random 15-bit tile pattern generator for the board-fill path. On a request it advances a free-running 16-bit LFSR for a fixed number of cycles, rejects patterns with too few set bits, and holds an accepted pattern stable. `pattern[0]`..`pattern[14]` drive the board-mapping stage's `in1`..`in15`, which fans them out to the 36 board cells.

---
 rtl/tile_pattern_gen_if.sv | 11 +
 rtl/tile_pattern_gen.sv | 78 +++++++
 tb/tb_tile_pattern_gen.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/tile_pattern_gen_if.sv
// tile_pattern_gen_if: request/pattern bus between the board-fill controller and the generator
interface tile_pattern_gen_if;
    logic req;
    logic seed_btn;
    logic busy;
    logic valid;
    logic done;
    logic [14:0] pattern;
    modport master (output req, seed_btn, input busy, valid, done, pattern);
    modport slave (input req, seed_btn, output busy, valid, done, pattern);
endinterface

// File: rtl/tile_pattern_gen.sv
// tile_pattern_gen: LFSR tile pattern generator with popcount rejection; TILE_PATTERN_GEN_ENTROPY_EN mixes in seed_btn entropy
module tile_pattern_gen #(
    parameter int SPIN_CYCLES = 32,
    parameter int MIN_ONES = 4,
    parameter int MAX_RETRIES = 3
) (
    input logic clk,
    input logic rst,
    tile_pattern_gen_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SPIN, CHECK, HOLD} state_t;
    localparam logic [7:0] SPIN_LOAD = 8'(SPIN_CYCLES - 1);
    state_t state, state_nx;
    logic [15:0] lfsr, lfsr_mix, lfsr_nx;
    logic [7:0] cnt, cnt_nx;
    logic [2:0] retries, retries_nx;
    logic [14:0] pattern_nx;
    logic valid_nx, done_nx, accept;
    int ones;
`ifdef TILE_PATTERN_GEN_ENTROPY_EN
    logic [7:0] free_cnt;
    always_ff @(posedge clk) free_cnt <= rst ? 8'd0 : free_cnt + 8'd1;
    assign lfsr_mix = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000) ^ (bus.seed_btn ? {8'h00, free_cnt} : 16'h0000);
`else
    assign lfsr_mix = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
`endif
    assign lfsr_nx = lfsr_mix == 16'h0000 ? 16'h0001 : lfsr_mix;
    assign ones = $countones(lfsr[14:0]);
    assign accept = ones >= MIN_ONES;
    assign bus.busy = state == SPIN || state == CHECK;
    always_comb begin
        state_nx = state;
        cnt_nx = cnt;
        retries_nx = retries;
        pattern_nx = bus.pattern;
        valid_nx = bus.valid;
        done_nx = 1'b0;
        case (state)
            IDLE, HOLD: if (bus.req) begin
                state_nx = SPIN;
                cnt_nx = SPIN_LOAD;
                retries_nx = '0;
                valid_nx = 1'b0;
            end
            SPIN: if (cnt == 8'd0) state_nx = CHECK;
                  else cnt_nx = cnt - 8'd1;
            CHECK: if (accept || int'(retries) == MAX_RETRIES) begin
                pattern_nx = accept ? lfsr[14:0] : 15'h7FFF;
                valid_nx = 1'b1;
                done_nx = 1'b1;
                state_nx = HOLD;
            end else begin
                retries_nx = retries + 3'd1;
                cnt_nx = SPIN_LOAD;
                state_nx = SPIN;
            end
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            lfsr <= 16'hACE1;
            cnt <= '0;
            retries <= '0;
            bus.pattern <= '0;
            bus.valid <= 1'b0;
            bus.done <= 1'b0;
        end else begin
            state <= state_nx;
            lfsr <= lfsr_nx;
            cnt <= cnt_nx;
            retries <= retries_nx;
            bus.pattern <= pattern_nx;
            bus.valid <= valid_nx;
            bus.done <= done_nx;
        end
    end
endmodule

// File: tb/tb_tile_pattern_gen.sv
// tb_tile_pattern_gen: three generator configurations checked every cycle against a transaction-level model
module tb_tile_pattern_gen;
`ifdef TILE_PATTERN_GEN_ENTROPY_EN
    localparam bit ENT = 1'b1;
`else
    localparam bit ENT = 1'b0;
`endif
    logic clk = 1'b0, rst = 1'b1, req = 1'b0, seed_btn = 1'b0;
    int checks = 0, errors = 0;
    always #5 clk = ~clk;

    tile_pattern_gen_if ifc0 ();
    tile_pattern_gen_if ifc1 ();
    tile_pattern_gen_if ifc2 ();
    assign ifc0.req = req;
    assign ifc1.req = req;
    assign ifc2.req = req;
    assign ifc0.seed_btn = seed_btn;
    assign ifc1.seed_btn = seed_btn;
    assign ifc2.seed_btn = seed_btn;

    tile_pattern_gen #(.SPIN_CYCLES(4), .MIN_ONES(0), .MAX_RETRIES(3)) u0 (.clk(clk), .rst(rst), .bus(ifc0));
    tile_pattern_gen #(.SPIN_CYCLES(4), .MIN_ONES(15), .MAX_RETRIES(2)) u1 (.clk(clk), .rst(rst), .bus(ifc1));
    tile_pattern_gen #(.SPIN_CYCLES(32), .MIN_ONES(4), .MAX_RETRIES(3)) u2 (.clk(clk), .rst(rst), .bus(ifc2));

    function automatic int sp(int i); return i == 2 ? 32 : 4; endfunction
    function automatic int mo(int i); return i == 0 ? 0 : (i == 1 ? 15 : 4); endfunction
    function automatic int mr(int i); return i == 1 ? 2 : 3; endfunction
    function automatic int pop(logic [14:0] v);
        int c = 0;
        for (int b = 0; b < 15; b++) c += int'(v[b]);
        return c;
    endfunction
    function automatic logic [15:0] step(logic [15:0] v, logic [7:0] fc, logic sb);
        logic [15:0] n = (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
        if (ENT && sb) n ^= {8'h00, fc};
        return n == 16'h0000 ? 16'h0001 : n;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: each generation is timed by edges elapsed since its request; attempt k is judged at edge k*(SPIN+1)
    logic [15:0] m_lfsr;
    logic [7:0] m_fc;
    logic m_busy [3], m_valid [3], m_done [3];
    logic [14:0] m_pat [3];
    int m_t [3], m_att [3];
    bit mready = 0;

    task automatic cmp(int i, logic b, logic v, logic d, logic [14:0] p);
        chk($sformatf("u%0d.busy", i), 32'(b), 32'(m_busy[i]));
        chk($sformatf("u%0d.valid", i), 32'(v), 32'(m_valid[i]));
        chk($sformatf("u%0d.done", i), 32'(d), 32'(m_done[i]));
        chk($sformatf("u%0d.pattern", i), 32'(p), 32'(m_pat[i]));
    endtask

    // Compare outputs of the last posedge, then advance the model for the coming posedge
    always @(negedge clk) begin
        if (mready) begin
            cmp(0, ifc0.busy, ifc0.valid, ifc0.done, ifc0.pattern);
            cmp(1, ifc1.busy, ifc1.valid, ifc1.done, ifc1.pattern);
            cmp(2, ifc2.busy, ifc2.valid, ifc2.done, ifc2.pattern);
            chk("lfsr", 32'(u0.lfsr), 32'(m_lfsr));
        end
        if (rst) begin
            m_lfsr = 16'hACE1;
            m_fc = 8'd0;
            for (int i = 0; i < 3; i++) begin
                m_busy[i] = 0; m_valid[i] = 0; m_done[i] = 0; m_pat[i] = '0; m_t[i] = 0;
            end
            mready = 1;
        end else if (mready) begin
            for (int i = 0; i < 3; i++) begin
                m_done[i] = 0;
                if (!m_busy[i]) begin
                    if (req) begin m_busy[i] = 1; m_t[i] = 0; m_valid[i] = 0; end
                end else begin
                    m_t[i]++;
                    if (m_t[i] % (sp(i) + 1) == 0) begin
                        int att;
                        bit ok;
                        att = m_t[i] / (sp(i) + 1);
                        ok = pop(m_lfsr[14:0]) >= mo(i);
                        if (ok || att == mr(i) + 1) begin
                            m_pat[i] = ok ? m_lfsr[14:0] : 15'h7FFF;
                            m_valid[i] = 1; m_done[i] = 1; m_busy[i] = 0; m_att[i] = att;
                        end
                    end
                end
            end
            m_lfsr = step(m_lfsr, m_fc, seed_btn);
            m_fc = m_fc + 8'd1;
        end
    end

    task automatic tick(int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic first_request(string tag);
        req = 1; tick();
        req = 0; tick(4);
        chk({tag, "_busy_e4"}, 32'(ifc0.busy), 1);
        chk({tag, "_valid_e4"}, 32'(ifc0.valid), 0);
        tick();
        chk({tag, "_valid_e5"}, 32'(ifc0.valid), 1);
        chk({tag, "_done_e5"}, 32'(ifc0.done), 1);
        chk({tag, "_pattern_e5"}, 32'(ifc0.pattern), 32'h0E27);
        tick();
        chk({tag, "_done_e6"}, 32'(ifc0.done), 0);
        chk({tag, "_valid_e6"}, 32'(ifc0.valid), 1);
    endtask

    initial begin
        int cnt_done, cnt_valid, w;
        logic [14:0] p0;
        tick(2);
        chk("rst_pattern", 32'(ifc0.pattern), 0);
        chk("rst_valid", 32'(ifc0.valid), 0);
        chk("rst_busy", 32'(ifc0.busy), 0);
        chk("rst_done", 32'(ifc0.done), 0);
        rst = 0;
        req = 1; tick();
        chk("model_lfsr_e0", 32'(m_lfsr), 32'hE270);
        chk("dut_lfsr_e0", 32'(u0.lfsr), 32'hE270);
        req = 0; tick(4);
        chk("lat_valid_e4", 32'(ifc0.valid), 0);
        chk("lat_busy_e4", 32'(ifc0.busy), 1);
        tick();
        chk("lat_valid_e5", 32'(ifc0.valid), 1);
        chk("lat_done_e5", 32'(ifc0.done), 1);
        chk("lat_busy_e5", 32'(ifc0.busy), 0);
        chk("lat_pattern_e5", 32'(ifc0.pattern), 32'h0E27);
        tick();
        chk("lat_done_e6", 32'(ifc0.done), 0);
        tick(8);
        chk("fb_valid_e14", 32'(ifc1.valid), 0);
        chk("fb_busy_e14", 32'(ifc1.busy), 1);
        tick();
        chk("fb_valid_e15", 32'(ifc1.valid), 1);
        chk("fb_pattern_e15", 32'(ifc1.pattern), 32'h7FFF);
        chk("fb_attempts", 32'(m_att[1]), 3);
        // request from HOLD, with a second pulse during SPIN that must be ignored
        req = 1; tick();
        chk("hold_valid_drop", 32'(ifc0.valid), 0);
        req = 0; tick();
        req = 1; tick();
        req = 0; tick(2);
        chk("ign_valid_e4", 32'(ifc0.valid), 0);
        tick();
        chk("ign_valid_e5", 32'(ifc0.valid), 1);
        chk("ign_done_e5", 32'(ifc0.done), 1);
        // held request: u0 regenerates every SPIN+2 edges, valid high one cycle each time
        req = 1;
        cnt_done = 0; cnt_valid = 0;
        for (int i = 0; i < 36; i++) begin
            tick();
            cnt_done += int'(ifc0.done);
            cnt_valid += int'(ifc0.valid);
        end
        req = 0;
        chk("held_done_count", 32'(cnt_done), 6);
        chk("held_valid_count", 32'(cnt_valid), 6);
        tick(8);
        // reset in the second SPIN cycle
        req = 1; tick();
        req = 0; tick();
        rst = 1; tick();
        chk("mid_busy", 32'(ifc0.busy), 0);
        chk("mid_pattern", 32'(ifc0.pattern), 0);
        chk("mid_valid", 32'(ifc0.valid), 0);
        chk("mid_lfsr", 32'(u0.lfsr), 32'hACE1);
        rst = 0;
        first_request("post_rst");
        w = 0;
        while (ifc2.busy && w < 300) begin tick(); w++; end
        chk("u2_settle_timeout", 32'(ifc2.busy), 0);
        for (int i = 0; i < 64; i++) begin
            seed_btn = i[0];
            req = 1; tick();
            req = 0;
            w = 0;
            while (!ifc2.valid && w < 200) begin tick(); w++; end
            chk("req64_timeout", 32'(ifc2.valid), 1);
            chk("req64_min_ones", 32'(pop(ifc2.pattern) >= 4), 1);
            chk("req64_lfsr_nonzero", 32'(u2.lfsr != 16'h0), 1);
        end
        seed_btn = 0;
        tick(2);
`ifdef TILE_PATTERN_GEN_ENTROPY_EN
        rst = 1; tick(2); rst = 0;
        first_request("ent_off");
        p0 = ifc0.pattern;
        rst = 1; tick(2); rst = 0;
        seed_btn = 1;
        req = 1; tick();
        req = 0; tick(5);
        chk("ent_on_valid", 32'(ifc0.valid), 1);
        chk("ent_patterns_differ", 32'(ifc0.pattern != p0), 1);
        seed_btn = 0;
        tick(2);
`else
        p0 = ifc0.pattern;
        tick();
        chk("hold_stable", 32'(ifc0.pattern), 32'(p0));
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
